// File: rtl/lsu.sv
// Load/store unit: one handshaked request at a time, aligned word access on the
// data bus, store lane replication/strobes and load extraction/extension.
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_ctr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wd,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rd,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state_q;
  logic        we_q;
  logic [2:0]  ctr_q;
  logic [1:0]  off_q;
  logic        mem_valid_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wmask_q;
  logic        resp_valid_q;
  logic [31:0] resp_rd_q;
  logic        resp_err_q;

  // ctr[1:0] encodes the access size (byte/half/word), ctr[2] selects zero-extension.
  function automatic logic req_legal(input logic [2:0] ctr, input logic [1:0] off);
    case (ctr)
      3'b000, 3'b100: return 1'b1;
      3'b001, 3'b101: return ~off[0];
      3'b010:         return off == 2'b00;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] ctr, input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (ctr)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return rdata;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      ctr_q        <= 3'd0;
      off_q        <= 2'd0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_wmask_q  <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_rd_q    <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q  <= req_we;
            ctr_q <= req_ctr;
            off_q <= req_addr[1:0];
            if (req_legal(req_ctr, req_addr[1:0])) begin
              state_q     <= REQ;
              mem_valid_q <= 1'b1;
              mem_we_q    <= req_we;
              mem_addr_q  <= {req_addr[31:2], 2'b00};
              mem_wdata_q <= req_we ? store_data(req_ctr[1:0], req_wd) : 32'd0;
              mem_wmask_q <= req_we ? store_mask(req_ctr[1:0], req_addr[1:0]) : 4'd0;
            end else begin
              // Rejected requests answer directly without touching the bus.
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rd_q    <= 32'd0;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rd_q    <= we_q ? 32'd0 : load_extend(ctr_q, off_q, mem_rdata);
          end
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign mem_valid  = mem_valid_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wmask  = mem_wmask_q;
  assign resp_valid = resp_valid_q;
  assign resp_rd    = resp_rd_q;
  assign resp_err   = resp_err_q;

endmodule
